// File: rtl/j_stlatch_bank.sv
// j_stlatch_bank: bank of addressed hold latches, direct or shadow+commit, with sticky update flags
module j_stlatch_bank #(
  parameter int WIDTH = 16,
  parameter int NCH = 4,
  parameter int ADDR_W = 2,
  parameter int DBUF = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 resl,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 load,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic [NCH*WIDTH-1:0] q,
  output logic [NCH-1:0]       pending,
  output logic [NCH-1:0]       dirty,
  input  logic [NCH-1:0]       clr_dirty
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] act, shd;
    logic pnd, drt, hit, commit;
    // gating with resl keeps the transparent path at RESET_VAL while in reset
    assign hit = resl && wr_en && wr_addr == ADDR_W'(c);
    assign commit = (DBUF != 0) ? load && (pnd || hit) : hit;
    always_ff @(posedge clk or negedge resl)
      if (!resl) begin
        act <= RESET_VAL;
        shd <= RESET_VAL;
        pnd <= 1'b0;
        drt <= 1'b0;
      end else begin
        if (commit) act <= (DBUF != 0 && !hit) ? shd : wr_data;
        if (hit) shd <= wr_data;
        pnd <= (DBUF != 0) && !load && (pnd || hit);
        drt <= commit || (drt && !clr_dirty[c]);
      end
    assign q[c*WIDTH +: WIDTH] = (DBUF == 0 && hit) ? wr_data : act;
    assign pending[c] = pnd;
    assign dirty[c] = drt;
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++)
      if (rd_addr == ADDR_W'(i)) rd_data = q[i*WIDTH +: WIDTH];
  end
endmodule

// File: tb/tb_j_stlatch_bank.sv
// tb_j_stlatch_bank: directed checks of direct, double-buffered and short-bank latch instances
module tb_j_stlatch_bank;
  logic clk = 0, resl = 0;
  logic [1:0] addr = 0, rd_addr = 0;
  logic [15:0] data = 0;
  logic we0 = 0, we1 = 0, we2 = 0, ld0 = 0, ld1 = 0, ld2 = 0;
  logic [3:0] clr0 = 0, clr1 = 0;
  logic [2:0] clr2 = 0;
  logic [15:0] rd0, rd1, rd2;
  logic [63:0] q0, q1;
  logic [47:0] q2;
  logic [3:0] pend0, pend1, dirty0, dirty1;
  logic [2:0] pend2, dirty2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  j_stlatch_bank #(.WIDTH(16), .NCH(4), .ADDR_W(2), .DBUF(0), .RESET_VAL(16'h0000)) u0 (
    .clk(clk), .resl(resl), .wr_en(we0), .wr_addr(addr), .wr_data(data), .load(ld0),
    .rd_addr(rd_addr), .rd_data(rd0), .q(q0), .pending(pend0), .dirty(dirty0), .clr_dirty(clr0));
  j_stlatch_bank #(.WIDTH(16), .NCH(4), .ADDR_W(2), .DBUF(1), .RESET_VAL(16'h0000)) u1 (
    .clk(clk), .resl(resl), .wr_en(we1), .wr_addr(addr), .wr_data(data), .load(ld1),
    .rd_addr(rd_addr), .rd_data(rd1), .q(q1), .pending(pend1), .dirty(dirty1), .clr_dirty(clr1));
  j_stlatch_bank #(.WIDTH(16), .NCH(3), .ADDR_W(2), .DBUF(1), .RESET_VAL(16'h0000)) u2 (
    .clk(clk), .resl(resl), .wr_en(we2), .wr_addr(addr), .wr_data(data), .load(ld2),
    .rd_addr(rd_addr), .rd_data(rd2), .q(q2), .pending(pend2), .dirty(dirty2), .clr_dirty(clr2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    we0 = 1; addr = 2; data = 16'hA5A5;
    #1;
    chk("rst_q0", q0, 64'h0);
    chk("rst_dirty0", dirty0, 4'b0000);
    chk("rst_pend1", pend1, 4'b0000);
    chk("rst_q2", q2, 48'h0);
    tick; tick;
    we0 = 0; resl = 1;
    tick;
    chk("post_rst_q0", q0, 64'h0);
    chk("post_rst_dirty0", dirty0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk($sformatf("post_rst_rd0_%0d", i), rd0, 16'h0);
      chk($sformatf("post_rst_rd2_%0d", i), rd2, 16'h0);
    end
    we0 = 1; addr = 2; data = 16'hA5A5; rd_addr = 2;
    #1;
    chk("d0_transp_q", q0[47:32], 16'hA5A5);
    chk("d0_transp_rd", rd0, 16'hA5A5);
    chk("d0_dirty_pre", dirty0, 4'b0000);
    tick;
    we0 = 0;
    #1;
    chk("d0_hold_q", q0, 64'h0000_A5A5_0000_0000);
    chk("d0_dirty", dirty0, 4'b0100);
    chk("d0_pend", pend0, 4'b0000);
    clr0 = 4'b0100;
    tick;
    clr0 = 0;
    chk("d0_clr", dirty0, 4'b0000);
    we0 = 1; addr = 2; data = 16'h1111; clr0 = 4'b0100;
    tick;
    we0 = 0; clr0 = 0;
    chk("d0_set_wins", dirty0, 4'b0100);
    chk("d0_q_new", q0, 64'h0000_1111_0000_0000);
    we0 = 1; addr = 0; data = 16'h0000;
    tick;
    we0 = 0;
    chk("d0_same_val_dirty", dirty0, 4'b0101);
    we1 = 1; addr = 1; data = 16'h1234;
    tick;
    addr = 3; data = 16'hBEEF;
    tick;
    we1 = 0;
    chk("d1_pend", pend1, 4'b1010);
    chk("d1_q_unchanged", q1, 64'h0);
    chk("d1_dirty_pre", dirty1, 4'b0000);
    ld1 = 1;
    tick;
    ld1 = 0;
    chk("d1_commit_q", q1, 64'hBEEF_0000_1234_0000);
    chk("d1_commit_pend", pend1, 4'b0000);
    chk("d1_commit_dirty", dirty1, 4'b1010);
    clr1 = 4'b1111;
    tick;
    clr1 = 0;
    chk("d1_clr", dirty1, 4'b0000);
    ld1 = 1;
    tick;
    ld1 = 0;
    chk("d1_empty_load_q", q1, 64'hBEEF_0000_1234_0000);
    chk("d1_empty_load_dirty", dirty1, 4'b0000);
    we1 = 1; addr = 0; data = 16'h0001;
    tick;
    addr = 1; data = 16'h5555;
    tick;
    addr = 0; data = 16'h0002; ld1 = 1;
    tick;
    we1 = 0; ld1 = 0;
    chk("d1_coll_q", q1, 64'hBEEF_0000_5555_0002);
    chk("d1_coll_pend", pend1, 4'b0000);
    chk("d1_coll_dirty", dirty1, 4'b0011);
    we1 = 1; addr = 2; data = 16'h0003;
    tick;
    data = 16'h0004;
    tick;
    we1 = 0; clr1 = 4'b1111;
    tick;
    clr1 = 0;
    chk("d1_b2b_pend", pend1, 4'b0100);
    ld1 = 1;
    tick;
    ld1 = 0;
    chk("d1_b2b_q", q1, 64'hBEEF_0004_5555_0002);
    chk("d1_b2b_dirty", dirty1, 4'b0100);
    we2 = 1; addr = 3; data = 16'hFFFF;
    tick;
    we2 = 0;
    chk("ill_pend", pend2, 3'b000);
    chk("ill_dirty", dirty2, 3'b000);
    chk("ill_q", q2, 48'h0);
    ld2 = 1;
    tick;
    ld2 = 0;
    chk("ill_load_q", q2, 48'h0);
    chk("ill_load_dirty", dirty2, 3'b000);
    rd_addr = 3;
    #1;
    chk("ill_rd", rd2, 16'h0);
    we2 = 1; addr = 2; data = 16'h7777; ld2 = 1;
    tick;
    we2 = 0; ld2 = 0; rd_addr = 2;
    #1;
    chk("u2_top_rd", rd2, 16'h7777);
    we1 = 1;
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i); data = 16'hC000 + 16'(i);
      tick;
    end
    we1 = 0;
    chk("ar_pend_pre", pend1, 4'b1111);
    #2;
    resl = 0;
    #1;
    chk("ar_pend", pend1, 4'b0000);
    chk("ar_q1", q1, 64'h0);
    chk("ar_dirty1", dirty1, 4'b0000);
    chk("ar_q0", q0, 64'h0);
    #1;
    resl = 1;
    ld1 = 1;
    tick;
    ld1 = 0;
    chk("ar_load_q", q1, 64'h0);
    chk("ar_load_dirty", dirty1, 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
